// File: rtl/ula_seq_param.sv
// ---------------------------------------------------------------------------
// ula_seq_param
//
// Parametrised, handshaked ALU. One operation is in flight at a time. Operands
// and opcode are captured on a valid/ready handshake. The result and flags are
// presented on a second valid/ready handshake. Single-cycle operations go
// through EXEC. MUL runs an unsigned shift-add over WIDTH cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any operation in flight
//   in_valid   operand/opcode offered
//   in_ready   block idle, can accept an operation
//   a_in       operand A (WIDTH)
//   b_in       operand B (WIDTH)
//   opcode_in  operation select (4 bits, 11..15 illegal)
//   out_valid  result and flags valid
//   out_ready  consumer accepts the result
//   s          result (WIDTH)
//   flag_c     carry / borrow / multiplier high half nonzero / last bit shifted out
//   flag_z     s == 0
//   flag_n     s[WIDTH-1]
//   flag_v     signed overflow (ADD/SUB only)
//   flag_err   illegal opcode
// ---------------------------------------------------------------------------
module ula_seq_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       opcode_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             flag_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_XNOR = 4'd6;
    localparam logic [3:0] OP_CMP  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    // For WIDTH == 2 the "a < b" compare bit has no place in s and is dropped.
    localparam int               LT_BIT  = (WIDTH > 2) ? 2 : WIDTH - 1;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [3:0]             op_q, op_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       s_q, s_d;
    logic                   c_q, c_d;
    logic                   z_q, z_d;
    logic                   n_q, n_d;
    logic                   v_q, v_d;
    logic                   err_q, err_d;

    // ------------------------------------------------------------------
    // Single-cycle ALU on the captured operands
    // ------------------------------------------------------------------
    logic [WIDTH:0]         add_w;
    logic [WIDTH:0]         sub_w;
    logic [WIDTH:0]         shl_w;
    logic [WIDTH:0]         shr_w;
    logic [CNT_W-1:0]       sh_amt;
    logic                   sh_big;
    logic [WIDTH-1:0]       alu_s;
    logic                   alu_c;
    logic                   alu_v;
    logic                   alu_err;

    assign add_w  = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w  = {1'b0, a_q} - {1'b0, b_q};
    assign sh_amt = b_q[CNT_W-1:0];
    assign sh_big = (sh_amt >= WIDTH_C);
    // The extra bit on the outgoing side catches the last bit shifted out.
    assign shl_w  = {1'b0, a_q} << sh_amt;
    assign shr_w  = {a_q, 1'b0} >> sh_amt;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        alu_s   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                alu_s = add_w[WIDTH-1:0];
                alu_c = add_w[WIDTH];
                alu_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_s = sub_w[WIDTH-1:0];
                alu_c = sub_w[WIDTH];
                alu_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_s = a_q & b_q;
            OP_OR:   alu_s = a_q | b_q;
            OP_XOR:  alu_s = a_q ^ b_q;
            OP_NAND: alu_s = ~(a_q & b_q);
            OP_XNOR: alu_s = ~(a_q ^ b_q);
            OP_CMP: begin
                alu_s[0] = (a_q == b_q);
                alu_s[1] = (a_q > b_q);
                if (WIDTH > 2) alu_s[LT_BIT] = (a_q < b_q);
            end
            OP_SHL: begin
                if (!sh_big) begin
                    alu_s = shl_w[WIDTH-1:0];
                    alu_c = shl_w[WIDTH];
                end
            end
            OP_SHR: begin
                if (!sh_big) begin
                    alu_s = shr_w[WIDTH:1];
                    alu_c = shr_w[0];
                end
            end
            default: alu_err = 1'b1;   // MUL never reaches EXEC; 11..15 illegal
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier step.
    // acc holds {partial product high half, remaining multiplier bits}. Each
    // step conditionally adds A to the high half and shifts right by one, so
    // after WIDTH steps acc is the full 2*WIDTH-bit product.
    // ------------------------------------------------------------------
    logic [WIDTH:0] mul_sum;

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);

    // ------------------------------------------------------------------
    // Next-state and result-write logic
    // ------------------------------------------------------------------
    logic             wr_en;
    logic [WIDTH-1:0] wr_s;
    logic             wr_c;
    logic             wr_v;
    logic             wr_err;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        wr_en   = 1'b0;
        wr_s    = '0;
        wr_c    = 1'b0;
        wr_v    = 1'b0;
        wr_err  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    op_d    = opcode_in;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, b_in};
                    state_d = (opcode_in == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            // EXEC spends two cycles so single-cycle ops share the MUL
            // pattern: the result registers load on the edge into DONE.
            S_EXEC: begin
                if (cnt_q == '0) begin
                    cnt_d = ONE_C;
                end else begin
                    wr_en   = 1'b1;
                    wr_s    = alu_s;
                    wr_c    = alu_c;
                    wr_v    = alu_v;
                    wr_err  = alu_err;
                    state_d = S_DONE;
                end
            end
            S_MUL: begin
                if (cnt_q == WIDTH_C) begin
                    wr_en   = 1'b1;
                    wr_s    = acc_q[WIDTH-1:0];
                    wr_c    = |acc_q[2*WIDTH-1:WIDTH];
                    state_d = S_DONE;
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_DONE: begin
                // in_ready is low here, so a simultaneous in_valid is ignored.
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        s_d   = wr_en ? wr_s            : s_q;
        c_d   = wr_en ? wr_c            : c_q;
        v_d   = wr_en ? wr_v            : v_q;
        err_d = wr_en ? wr_err          : err_q;
        z_d   = wr_en ? (wr_s == '0)    : z_q;
        n_d   = wr_en ? wr_s[WIDTH-1]   : n_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign s         = s_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_v    = v_q;
    assign flag_err  = err_q;

endmodule

// File: tb/tb_ula_seq_param.sv
// ---------------------------------------------------------------------------
// tb_ula_seq_param
//
// Directed bench for ula_seq_param with two instances, WIDTH=8 and WIDTH=16,
// sharing clock and reset. Flags are compared as a packed
// {flag_c, flag_z, flag_n, flag_v, flag_err} vector.
// ---------------------------------------------------------------------------
module tb_ula_seq_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH = 8 instance
    logic       iv8, ir8, ov8, ordy8;
    logic [7:0] a8, b8, s8;
    logic [3:0] op8;
    logic       c8, z8, n8, v8, e8;

    // WIDTH = 16 instance
    logic        iv16, ir16, ov16, ordy16;
    logic [15:0] a16, b16, s16;
    logic [3:0]  op16;
    logic        c16, z16, n16, v16, e16;

    ula_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a_in(a8), .b_in(b8), .opcode_in(op8),
        .out_valid(ov8), .out_ready(ordy8),
        .s(s8), .flag_c(c8), .flag_z(z8), .flag_n(n8), .flag_v(v8), .flag_err(e8)
    );

    ula_seq_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16),
        .a_in(a16), .b_in(b16), .opcode_in(op16),
        .out_valid(ov16), .out_ready(ordy16),
        .s(s16), .flag_c(c16), .flag_z(z16), .flag_n(n16), .flag_v(v16), .flag_err(e16)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic get_out(input bit wide, output logic [15:0] s_o, output logic [4:0] f_o,
                           output logic ov_o, output logic ir_o);
        if (wide) begin
            s_o = s16; f_o = {c16, z16, n16, v16, e16}; ov_o = ov16; ir_o = ir16;
        end else begin
            s_o = {8'h00, s8}; f_o = {c8, z8, n8, v8, e8}; ov_o = ov8; ir_o = ir8;
        end
    endtask

    // Issue one operation, measure edges from accept to out_valid, check the
    // result, then retire it.
    task automatic run_op(input string tag, input bit wide, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_s, input logic [4:0] exp_f, input int exp_lat);
        logic [15:0] so;
        logic [4:0]  fo;
        logic        ovo, iro;
        int          lat;
        bit          ready_seen;
        @(negedge clk);
        if (wide) begin iv16 = 1'b1; a16 = a; b16 = b; op16 = op; end
        else begin iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; op8 = op; end
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        iv16 = 1'b0;
        lat = 0;
        ready_seen = 1'b0;
        get_out(wide, so, fo, ovo, iro);
        while (!ovo && lat < 64) begin
            ready_seen |= iro;
            @(posedge clk);
            #1;
            lat++;
            get_out(wide, so, fo, ovo, iro);
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy in_ready"}, {31'd0, ready_seen}, 32'd0);
        check({tag, " s"}, {16'd0, so}, {16'd0, exp_s});
        check({tag, " flags"}, {27'd0, fo}, {27'd0, exp_f});
        @(negedge clk);
        ordy8 = 1'b1;
        ordy16 = 1'b1;
        @(posedge clk);
        #1;
        ordy8 = 1'b0;
        ordy16 = 1'b0;
        get_out(wide, so, fo, ovo, iro);
        check({tag, " retire"}, {30'd0, ovo, iro}, 32'b01);
    endtask

    initial begin
        logic [15:0] so;
        logic [4:0]  fo;
        logic        ovo, iro;
        bit          ov_seen;

        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; ordy8 = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; ordy16 = 1'b0;

        // Reset state of both instances
        #12;
        check("reset8 s/flags", {19'd0, s8, c8, z8, n8, v8, e8}, 32'd0);
        check("reset8 ov/ir", {30'd0, ov8, ir8}, 32'b01);
        check("reset16 s/flags", {11'd0, s16, c16, z16, n16, v16, e16}, 32'd0);
        check("reset16 ov/ir", {30'd0, ov16, ir16}, 32'b01);
        @(negedge clk);
        rst_n = 1'b1;

        // Start a MUL and abort it with reset part-way through
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'd3; b8 = 8'd5; op8 = 4'd8;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmul reset s/flags", {19'd0, s8, c8, z8, n8, v8, e8}, 32'd0);
        check("midmul reset ov/ir", {30'd0, ov8, ir8}, 32'b01);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #1;
            ov_seen |= ov8;
        end
        check("aborted mul no result", {31'd0, ov_seen}, 32'd0);

        // Flags vector is {c, z, n, v, err}
        run_op("add8 ff+01",  1'b0, 4'd0,  16'h00FF, 16'h0001, 16'h0000, 5'b11000, 2);
        run_op("sub8 80-01",  1'b0, 4'd1,  16'h0080, 16'h0001, 16'h007F, 5'b00010, 2);
        run_op("sub8 01-02",  1'b0, 4'd1,  16'h0001, 16'h0002, 16'h00FF, 5'b10100, 2);
        run_op("mul8 10*20",  1'b0, 4'd8,  16'h0010, 16'h0020, 16'h0000, 5'b11000, 9);
        run_op("mul8 13*11",  1'b0, 4'd8,  16'd13,   16'd11,   16'h008F, 5'b00100, 9);
        run_op("cmp8 5v9",    1'b0, 4'd7,  16'd5,    16'd9,    16'h0004, 5'b00000, 2);
        run_op("shl8 81<<1",  1'b0, 4'd9,  16'h0081, 16'd1,    16'h0002, 5'b10000, 2);
        run_op("shr8 81>>8",  1'b0, 4'd10, 16'h0081, 16'd8,    16'h0000, 5'b01000, 2);
        run_op("illegal8 12", 1'b0, 4'd12, 16'h0055, 16'h00AA, 16'h0000, 5'b01001, 2);

        // Backpressure: XNOR F0/0F, out_ready held low, in_valid pulses ignored
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; op8 = 4'd6;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv8 = 1'b1; a8 = 8'h01; b8 = 8'h02; op8 = 4'd0;
            @(posedge clk);
            #1;
            iv8 = 1'b0;
            get_out(1'b0, so, fo, ovo, iro);
            check($sformatf("xnor hold %0d", i), {9'd0, so, fo, ovo, iro}, {9'd0, 16'h0000, 5'b01000, 1'b1, 1'b0});
        end
        // Retire with in_valid high in the same cycle: new op must not be taken
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'h01; b8 = 8'h02; op8 = 4'd0;
        ordy8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        ordy8 = 1'b0;
        check("xnor retire ov/ir", {30'd0, ov8, ir8}, 32'b01);
        @(posedge clk);
        #1;
        check("no accept on retire", {30'd0, ov8, ir8}, 32'b01);

        // Same flow at WIDTH = 16
        run_op("add16",  1'b1, 4'd0, 16'hFFFF, 16'h0002, 16'h0001, 5'b10000, 2);
        run_op("sub16",  1'b1, 4'd1, 16'hFFFF, 16'h0002, 16'hFFFD, 5'b00100, 2);
        run_op("mul16",  1'b1, 4'd8, 16'hFFFF, 16'h0002, 16'hFFFE, 5'b10100, 17);
        run_op("cmp16",  1'b1, 4'd7, 16'hFFFF, 16'h0002, 16'h0002, 5'b00000, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
